// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT receive path: FSM encoding, frame defaults,
// parity mode constants and the idle line level.
package usrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int   DEFAULT_DATA_BITS = 8;
    localparam logic PAR_MODE_EVEN     = 1'b0;
    localparam logic PAR_MODE_ODD      = 1'b1;
    localparam logic LINE_IDLE         = 1'b1;

    // Expected parity bit; zero-extended data does not disturb the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd_mode);
        return (^data) ^ odd_mode;
    endfunction

endpackage

// File: rtl/usrt_rx_if.sv
// Push/full handshake between the USRT receiver and the RX data register.
interface usrt_rx_if;
    logic [7:0] o_Data;
    logic       o_Push;
    logic       i_Full;

    modport master (output o_Data, output o_Push, input i_Full);
    modport slave  (input o_Data, input o_Push, output i_Full);
endinterface

// File: rtl/usrt_sync_edge.sv
// Multi-stage synchroniser with a registered one-cycle rising-edge strobe.
module usrt_sync_edge
    import usrt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;
    logic                   rise_r;

    // Synchroniser chain, edge history and registered strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{LINE_IDLE}};
            prev_r  <= LINE_IDLE;
            rise_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], din};
            prev_r  <= chain_r[SYNC_STAGES-1];
            rise_r  <= ~prev_r & chain_r[SYNC_STAGES-1];
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/usrt_rx.sv
// USRT serial receive engine: samples data on externally clocked Sclk rises,
// deserialises start/data/parity/stop and pushes good bytes to the RX register.
module usrt_rx
    import usrt_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_Pclk,
    input  logic             i_Reset,
    input  logic             i_Enable,
    input  logic             i_Sclk,
    input  logic             i_Rx,
    input  logic             i_Clr_Err,
    usrt_rx_if.master        rx_bus,
    output logic             o_Busy,
    output logic             o_Overrun,
    output logic             o_Frame_Err,
    output logic             o_Parity_Err
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    rx_state_e              state_r, next_state_s;
    logic [SYNC_STAGES-1:0] rx_sync_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   frame_bad_r;
    logic [7:0]             data_r;
    logic                   push_r, overrun_r, frame_err_r, parity_err_r;
    logic                   strobe_s, rx_s;
    logic                   cnt_clr_s, cnt_inc_s, shift_en_s, par_chk_s, stop_s;
    logic                   good_s, set_fe_s, set_pe_s, set_ov_s, push_s, par_bad_s;

    usrt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (i_Pclk),
        .reset (i_Reset),
        .din   (i_Sclk),
        .rise  (strobe_s)
    );

    // Data line chain of the same depth keeps rx aligned with the Sclk strobe.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            rx_sync_r <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], i_Rx};
        end
    end

    assign rx_s = rx_sync_r[SYNC_STAGES-1];

    // State register.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and datapath controls; a dropped enable aborts regardless of strobe.
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        shift_en_s   = 1'b0;
        par_chk_s    = 1'b0;
        stop_s       = 1'b0;
        if ((state_r != ST_IDLE) && !i_Enable) begin
            next_state_s = ST_IDLE;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s && i_Enable) begin
                        next_state_s = ST_DATA;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        next_state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
                ST_PARITY: begin
                    par_chk_s    = 1'b1;
                    next_state_s = ST_STOP;
                end
                ST_STOP: begin
                    stop_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    assign par_bad_s = par_chk_s && (rx_s != calc_parity(8'(shift_r), PAR_MODE));
    assign good_s    = stop_s & rx_s & ~frame_bad_r;
    assign set_fe_s  = stop_s & ~rx_s;
    assign set_pe_s  = stop_s & rx_s & frame_bad_r;
    assign set_ov_s  = good_s & rx_bus.i_Full;
    assign push_s    = good_s & ~rx_bus.i_Full;

    // Shift register, bit counter, frame outcome and sticky error flags.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            shift_r      <= '0;
            bit_cnt_r    <= 3'd0;
            frame_bad_r  <= 1'b0;
            data_r       <= 8'd0;
            push_r       <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (cnt_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (cnt_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (cnt_clr_s) begin
                frame_bad_r <= 1'b0;
            end else if (par_bad_s) begin
                frame_bad_r <= 1'b1;
            end
            if (shift_en_s) begin
                shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            end
            push_r <= push_s;
            if (push_s) begin
                data_r <= 8'(shift_r);
            end
            // A new error event outranks a coincident clear.
            if (set_ov_s)       overrun_r <= 1'b1;
            else if (i_Clr_Err) overrun_r <= 1'b0;
            if (set_fe_s)       frame_err_r <= 1'b1;
            else if (i_Clr_Err) frame_err_r <= 1'b0;
            if (set_pe_s)       parity_err_r <= 1'b1;
            else if (i_Clr_Err) parity_err_r <= 1'b0;
        end
    end

    assign rx_bus.o_Data = data_r;
    assign rx_bus.o_Push = push_r;
    assign o_Busy        = (state_r != ST_IDLE);
    assign o_Overrun     = overrun_r;
    assign o_Frame_Err   = frame_err_r;
    assign o_Parity_Err  = parity_err_r;

endmodule

// File: tb/tb_usrt_rx.sv
// Directed bench for usrt_rx: a no-parity instance and an even-parity instance
// share the data line, each with its own serial clock.
module tb_usrt_rx;

    logic clk = 1'b0;
    logic reset, enable, rx, clr_err, sclk_a, sclk_b;
    logic busy_a, ov_a, fe_a, pe_a;
    logic busy_b, ov_b, fe_b, pe_b;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   push_cyc = 0;
    int   busy_lo = 0;
    logic busy_mon = 1'b0;
    logic [7:0] push_q[$];
    logic [7:0] push_qb[$];
    int   n0;

    usrt_rx_if if_a ();
    usrt_rx_if if_b ();

    usrt_rx u_dut (
        .i_Pclk(clk), .i_Reset(reset), .i_Enable(enable), .i_Sclk(sclk_a), .i_Rx(rx),
        .i_Clr_Err(clr_err), .rx_bus(if_a), .o_Busy(busy_a), .o_Overrun(ov_a),
        .o_Frame_Err(fe_a), .o_Parity_Err(pe_a)
    );

    usrt_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .i_Pclk(clk), .i_Reset(reset), .i_Enable(enable), .i_Sclk(sclk_b), .i_Rx(rx),
        .i_Clr_Err(clr_err), .rx_bus(if_b), .o_Busy(busy_b), .o_Overrun(ov_b),
        .o_Frame_Err(fe_b), .o_Parity_Err(pe_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if_a.o_Push === 1'b1) begin
            push_q.push_back(if_a.o_Data);
            push_cyc = cyc;
        end
        if (if_b.o_Push === 1'b1) push_qb.push_back(if_b.o_Data);
        if (busy_mon && (busy_a === 1'b0)) busy_lo++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One serial bit: data set while Sclk is low, Sclk high for 4 cycles then low for 4.
    task automatic drive_bit(input logic b, input logic sel);
        rx = b;
        repeat (4) @(posedge clk);
        #1;
        if (sel) sclk_b = 1'b1; else sclk_a = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
        sclk_a = 1'b0;
        sclk_b = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic sel, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, sel);
        for (int i = 0; i < 8; i++) drive_bit(d[i], sel);
        if (par_en) drive_bit(par_bit, sel);
        drive_bit(stop_bit, sel);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1; enable = 1'b1; rx = 1'b1; clr_err = 1'b0;
        sclk_a = 1'b0; sclk_b = 1'b0;
        if_a.i_Full = 1'b0;
        if_b.i_Full = 1'b0;

        // Reset with the line toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rx = ~rx;
            sclk_a = ~sclk_a;
        end
        check("rst_data", 32'(if_a.o_Data), 32'h0);
        check("rst_push", 32'(if_a.o_Push), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_errs", 32'({ov_a, fe_a, pe_a}), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; rx = 1'b1; sclk_a = 1'b0;
        for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("idle_no_push", 32'(push_q.size()), 32'd0);
        check("idle_busy", 32'(busy_a), 32'h0);

        // Single frame 0xA5 and its push latency.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_count", 32'(push_q.size()), 32'd1);
        check("a5_data", 32'(push_q[0]), 32'hA5);
        check("a5_latency", 32'(push_cyc - rise_cyc), 32'd4);
        check("a5_errs", 32'({ov_a, fe_a, pe_a}), 32'h0);

        // Back-to-back 0x00 then 0xFF with no idle bit.
        d = 8'h00;
        drive_bit(1'b0, 1'b0);
        busy_mon = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
        drive_bit(1'b1, 1'b0);
        d = 8'hFF;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
        busy_mon = 1'b0;
        drive_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk); #1;
        check("b2b_count", 32'(push_q.size()), 32'd3);
        check("b2b_first", 32'(push_q[1]), 32'h00);
        check("b2b_second", 32'(push_q[2]), 32'hFF);
        check("b2b_busy_gap_le8", 32'(busy_lo <= 8), 32'd1);

        // Overrun on a full register, sticky across a good frame, then cleared.
        if_a.i_Full = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_no_push", 32'(push_q.size()), 32'd3);
        check("ovr_flag", 32'(ov_a), 32'h1);
        check("ovr_data_held", 32'(if_a.o_Data), 32'hFF);
        if_a.i_Full = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_next_push", 32'(push_q.size()), 32'd4);
        check("ovr_next_data", 32'(push_q[3]), 32'h11);
        check("ovr_sticky", 32'(ov_a), 32'h1);
        pulse_clr();
        check("ovr_cleared", 32'(ov_a), 32'h0);

        // Stop bit sampled low.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fe_flag", 32'({ov_a, fe_a, pe_a}), 32'b010);
        check("fe_no_push", 32'(push_q.size()), 32'd4);
        pulse_clr();
        check("fe_cleared", 32'(fe_a), 32'h0);

        // Even parity: 0x07 needs parity bit 1.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        check("par_good_count", 32'(push_qb.size()), 32'd1);
        check("par_good_data", 32'(push_qb[0]), 32'h07);
        check("par_good_flag", 32'(pe_b), 32'h0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        check("par_bad_flag", 32'({ov_b, fe_b, pe_b}), 32'b001);
        check("par_bad_no_push", 32'(push_qb.size()), 32'd1);

        // Enable dropped after 4 data bits of 0x5A.
        d = 8'h5A;
        n0 = push_q.size();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        check("en_busy_mid", 32'(busy_a), 32'h1);
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1;
        check("en_abort_idle", 32'(busy_a), 32'h0);
        for (int i = 4; i < 8; i++) drive_bit(d[i], 1'b0);
        drive_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk); #1;
        check("en_no_push", 32'(push_q.size() - n0), 32'd0);
        check("en_no_err", 32'({ov_a, fe_a, pe_a}), 32'h0);
        enable = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        check("en_after_data", 32'(push_q[push_q.size()-1]), 32'h81);
        check("en_after_count", 32'(push_q.size() - n0), 32'd1);

        // Reset asserted after 4 data bits.
        n0 = push_q.size();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        rx = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_idle", 32'(busy_a), 32'h0);
        reset = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("rst_mid_no_push", 32'(push_q.size() - n0), 32'd0);
        check("rst_mid_data", 32'(if_a.o_Data), 32'h0);
        check("rst_mid_errs", 32'({ov_a, fe_a, pe_a}), 32'h0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_after_count", 32'(push_q.size() - n0), 32'd1);
        check("rst_after_data", 32'(if_a.o_Data), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usrt_rx.md
Name: usrt_rx

Overview:
Serial receive engine of the USRT. It samples an externally supplied serial clock and data line and deserialises one frame: start bit, DATA_BITS data bits LSB first, optional parity, stop bit. Each good byte is pushed into the RX data register through its push/full interface. Enable comes from the status register; error flags go back to it.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8); o_Data is zero-extended above DATA_BITS.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1).
SYNC_STAGES, 2, flip-flop stages on i_Sclk and i_Rx (minimum 2).

Ports:
i_Pclk  in  1  system clock; all logic on the rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Enable  in  1  receiver enable from the status register.
i_Sclk  in  1  external serial clock, asynchronous to i_Pclk.
i_Rx  in  1  serial data, asynchronous; idles high.
i_Full  in  1  RX data register full.
i_Clr_Err  in  1  one-cycle pulse; clears all sticky error flags.
o_Data  out  8  received byte; valid while o_Push=1 and held until the next push.
o_Push  out  1  one-cycle push strobe to the RX data register.
o_Busy  out  1  a frame is in progress (state is not IDLE).
o_Overrun  out  1  sticky: a good frame was dropped because i_Full=1.
o_Frame_Err  out  1  sticky: the stop bit was sampled as 0.
o_Parity_Err  out  1  sticky: parity mismatch.

Behaviour:
- Clock and reset: one clock, i_Pclk. Reset is synchronous and active-high on i_Reset.
- Reset values: state IDLE, all outputs 0, synchroniser flops 1 (line idle), shift register 0, bit counter 0.
- Synchronisation: i_Sclk and i_Rx pass through identical SYNC_STAGES chains so they stay aligned.
- Sample strobe: asserted for one cycle when the synchronised Sclk shows a 0->1 transition (previous 0, current 1).
  - Latency from an i_Sclk rise to the strobe is SYNC_STAGES+1 cycles.
  - Required ratio: i_Pclk >= 4x i_Sclk.
- The FSM advances only on strobe cycles. States:
  - IDLE: on strobe with rx=0 and i_Enable=1 -> DATA; clear bit counter. A strobe with rx=1 stays in IDLE.
  - DATA: on strobe, shift rx into the MSB side so bits land LSB first; count up. After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: on strobe, compare rx with the computed parity bit. Even parity: XOR of the data bits. Odd parity: its inverse. On mismatch, mark the frame bad. Then -> STOP.
  - STOP: on strobe, decide the frame outcome (next bullet), then -> IDLE.
- STOP outcome:
  - rx=0: set o_Frame_Err; no push.
  - Parity mismatch: set o_Parity_Err; no push.
  - Good frame and i_Full=1: set o_Overrun; byte dropped; o_Data unchanged.
  - Good frame and i_Full=0: o_Data <= byte and o_Push=1 for exactly one cycle, the cycle after the stop strobe.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted (no idle bit required).
- i_Enable deasserted mid-frame: abort to IDLE on the next cycle; no push, no error; partial data discarded.
- Error flags:
  - Sticky until i_Clr_Err or i_Reset.
  - If i_Clr_Err coincides with a new error event, the set wins.
  - Errors never block later frames.
- Reset mid-frame: state returns to IDLE; no push is generated for the partial frame.

Decomposition:
- Shared package usrt_pkg: FSM state encoding (IDLE, DATA, PARITY, STOP), the default DATA_BITS, the parity mode constants, and the idle line level constant (1).
- One sub-module, usrt_sync_edge: a SYNC_STAGES-deep synchroniser with rising-edge strobe. It is instantiated for i_Sclk; i_Rx uses a plain synchroniser chain of the same depth.

Test Plan:
- Reset: hold i_Reset 3 cycles with the line toggling -> all outputs 0 and o_Busy=0; no push for 10 Sclk periods of idle-high line.
- Single frame 0xA5, PARITY_EN=0: bits 0,1,0,1,0,0,1,0,1,1 -> one o_Push with o_Data=0xA5, SYNC_STAGES+2 cycles after the stop-bit Sclk rise; no errors.
- Back-to-back frames 0x00 then 0xFF -> exactly two pushes with data 0x00 then 0xFF; o_Busy drops for at most the gap cycles.
- i_Full=1 during frame 0x3C -> no push, o_Overrun=1. The next frame 0x11 with i_Full=0 pushes 0x11 and o_Overrun stays 1. i_Clr_Err pulse -> o_Overrun=0.
- Stop bit 0 on frame 0x55 -> o_Frame_Err=1, no push. With PARITY_EN=1 and even parity, frame 0x07 with parity bit 0 -> o_Parity_Err=1, no push.
- i_Enable dropped, or i_Reset asserted, after 4 data bits -> IDLE next cycle, no push, no error. A following full frame 0x81 is received correctly.
